// File: rtl/column_buffer_if.sv
// Avalon-MM slave bus of the column buffer: CPU descriptor writes and status reads.
// Read data is combinational with zero wait states.
interface column_buffer_if;
  logic [15:0] writedata;
  logic        write;
  logic        read;
  logic        chipselect;
  logic [1:0]  address;
  logic [15:0] readdata;

  modport master (
    output writedata, write, read, chipselect, address,
    input  readdata
  );

  modport slave (
    input  writedata, write, read, chipselect, address,
    output readdata
  );
endinterface

// File: rtl/column_buffer.sv
// Double-buffered per-column wall store: the CPU fills the back bank, the display reads
// the front bank and receives decoded wall top/bottom/colour/side two cycles later.
module column_buffer #(
  parameter int NUM_COLS = 640,
  parameter int SCREEN_H = 480,
  parameter int HORIZON  = 240
) (
  input  logic        clk,
  input  logic        reset,
  column_buffer_if.slave bus,
  input  logic        frame_start,
  input  logic        rd_en,
  input  logic [9:0]  rd_col,
  output logic        col_valid,
  output logic [9:0]  wall_top,
  output logic [9:0]  wall_bottom,
  output logic [5:0]  wall_color,
  output logic        wall_side
);

  localparam logic [9:0] NC10    = 10'(NUM_COLS);
  localparam logic [9:0] NC_LAST = 10'(NUM_COLS - 1);
  localparam logic [8:0] SH9     = 9'(SCREEN_H);
  localparam logic [9:0] HOR10   = 10'(HORIZON);

  logic [15:0] r_bank0 [NUM_COLS];
  logic [15:0] r_bank1 [NUM_COLS];

  logic        r_front_sel;
  logic        r_swap_pending;
  logic [9:0]  r_wr_ptr;

  logic        w_wr_en;
  logic        w_wr0;
  logic        w_wr1;
  logic        w_wr2;
  logic        w_swap;

  assign w_wr_en = bus.chipselect && bus.write;
  assign w_wr0   = w_wr_en && (bus.address == 2'd0);
  assign w_wr1   = w_wr_en && (bus.address == 2'd1);
  assign w_wr2   = w_wr_en && (bus.address == 2'd2);
  assign w_swap  = frame_start && r_swap_pending;

  // Later assignments override earlier ones: a swap resets the pointer over any
  // CPU pointer update, while a same-cycle swap request survives the swap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_front_sel    <= 1'b0;
      r_swap_pending <= 1'b0;
      r_wr_ptr       <= '0;
    end else begin
      if (w_wr0)
        r_wr_ptr <= (r_wr_ptr == NC_LAST) ? '0 : r_wr_ptr + 10'd1;
      if (w_wr1 && bus.writedata[1])
        r_wr_ptr <= '0;
      if (w_wr2 && (bus.writedata[9:0] < NC10))
        r_wr_ptr <= bus.writedata[9:0];
      if (w_swap) begin
        r_front_sel    <= ~r_front_sel;
        r_swap_pending <= 1'b0;
        r_wr_ptr       <= '0;
      end
      if (w_wr1 && bus.writedata[0])
        r_swap_pending <= 1'b1;
    end
  end

  always_comb begin
    bus.readdata = '0;
    if (bus.chipselect && bus.read) begin
      case (bus.address)
        2'd1:    bus.readdata = {14'b0, r_swap_pending, r_front_sel};
        2'd2:    bus.readdata = {6'b0, r_wr_ptr};
        default: bus.readdata = '0;
      endcase
    end
  end

  // Stage 1: RAM read of both banks; the bank choice is latched with the request.
  logic        w_oob;
  logic [9:0]  w_rd_idx;
  logic [15:0] r_rd0;
  logic [15:0] r_rd1;
  logic        r_s1_valid;
  logic        r_s1_oob;
  logic        r_s1_bank;

  assign w_oob    = (rd_col >= NC10);
  assign w_rd_idx = w_oob ? '0 : rd_col;

  always_ff @(posedge clk) begin
    if (w_wr0 && r_front_sel)
      r_bank0[r_wr_ptr] <= bus.writedata;
    if (rd_en)
      r_rd0 <= r_bank0[w_rd_idx];
  end

  always_ff @(posedge clk) begin
    if (w_wr0 && !r_front_sel)
      r_bank1[r_wr_ptr] <= bus.writedata;
    if (rd_en)
      r_rd1 <= r_bank1[w_rd_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_oob   <= 1'b0;
      r_s1_bank  <= 1'b0;
    end else begin
      r_s1_valid <= rd_en;
      if (rd_en) begin
        r_s1_oob  <= w_oob;
        r_s1_bank <= r_front_sel;
      end
    end
  end

  // Stage 2: clamp height, split symmetrically about the horizon.
  logic [15:0] w_word;
  logic [8:0]  w_height;
  logic [8:0]  w_h;
  logic [9:0]  w_half;

  assign w_word   = r_s1_bank ? r_rd1 : r_rd0;
  assign w_height = w_word[8:0];
  assign w_h      = r_s1_oob ? 9'd0 : ((w_height > SH9) ? SH9 : w_height);
  assign w_half   = {2'b00, w_h[8:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      col_valid   <= 1'b0;
      wall_top    <= '0;
      wall_bottom <= '0;
      wall_color  <= '0;
      wall_side   <= 1'b0;
    end else begin
      col_valid <= r_s1_valid;
      if (r_s1_valid) begin
        wall_top    <= HOR10 - w_half;
        wall_bottom <= HOR10 + w_half;
        wall_color  <= r_s1_oob ? 6'd0 : w_word[15:10];
        wall_side   <= r_s1_oob ? 1'b0 : w_word[9];
      end
    end
  end

endmodule

// File: tb/tb_column_buffer.sv
// Scoreboard bench for column_buffer: a bank/pointer model predicts status reads and
// decoded display results; a negedge monitor pops and compares each col_valid beat.
module tb_column_buffer;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic        rd_en;
  logic [9:0]  rd_col;
  logic        col_valid;
  logic [9:0]  wall_top;
  logic [9:0]  wall_bottom;
  logic [5:0]  wall_color;
  logic        wall_side;

  column_buffer_if bus ();

  column_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .frame_start (frame_start),
    .rd_en       (rd_en),
    .rd_col      (rd_col),
    .col_valid   (col_valid),
    .wall_top    (wall_top),
    .wall_bottom (wall_bottom),
    .wall_color  (wall_color),
    .wall_side   (wall_side)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // expected entry: {top[26:17], bottom[16:7], colour[6:1], side[0]}
  logic [26:0] exp_q[$];

  // reference model state
  logic [15:0] m_bank [2][640];
  bit          m_front;
  bit          m_pending;
  logic [9:0]  m_wrptr;

  function automatic logic [26:0] model_decode(input logic [9:0] col);
    int h;
    logic [15:0] w;
    logic [9:0] top, bot;
    if (int'(col) >= 640) return {10'd240, 10'd240, 6'd0, 1'b0};
    w = m_bank[m_front][col];
    h = int'(w[8:0]);
    if (h > 480) h = 480;
    top = 10'(240 - h / 2);
    bot = 10'(240 + h / 2);
    return {top, bot, w[15:10], w[9]};
  endfunction

  // one clock cycle of stimulus; the model is advanced by the rules for that edge
  task automatic step(input bit wr, input logic [1:0] a, input logic [15:0] d,
                      input bit fs, input bit rd, input logic [9:0] col);
    bit swap, set_req;
    bus.chipselect = wr;
    bus.write      = wr;
    bus.read       = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    frame_start    = fs;
    rd_en          = rd;
    rd_col         = col;
    if (rd) exp_q.push_back(model_decode(col));
    swap    = fs && m_pending;
    set_req = wr && (a == 2'd1) && d[0];
    if (wr && a == 2'd0) begin
      m_bank[~m_front][m_wrptr] = d;
      m_wrptr = (m_wrptr == 10'd639) ? 10'd0 : m_wrptr + 10'd1;
    end
    if (wr && a == 2'd1 && d[1]) m_wrptr = 10'd0;
    if (wr && a == 2'd2 && int'(d[9:0]) < 640) m_wrptr = d[9:0];
    if (swap) begin
      m_front   = ~m_front;
      m_pending = set_req;
      m_wrptr   = 10'd0;
    end else if (set_req) begin
      m_pending = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    frame_start    = 1'b0;
    rd_en          = 1'b0;
  endtask

  task automatic wr_word(input logic [1:0] a, input logic [15:0] d);
    step(1'b1, a, d, 1'b0, 1'b0, 10'd0);
  endtask

  task automatic rd_req(input logic [9:0] col);
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b1, col);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 10'd0);
  endtask

  task automatic do_swap();
    wr_word(2'd1, 16'h0001);
    step(1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 10'd0);
  endtask

  task automatic check_reg(input logic [1:0] a, input logic [15:0] expv, input string name);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = a;
    #1;
    n_checks++;
    if (bus.readdata !== expv) begin
      n_errors++;
      $display("FAIL %s: readdata=%h expected=%h", name, bus.readdata, expv);
    end
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.address    = 2'd0;
  endtask

  task automatic check_status(input string name);
    check_reg(2'd1, {14'b0, m_pending, m_front}, {name, "_addr1"});
    check_reg(2'd2, {6'b0, m_wrptr}, {name, "_addr2"});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && col_valid) begin
      logic [26:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL display_unexpected: col_valid=1 with no request outstanding");
      end else begin
        e = exp_q.pop_front();
        if ({wall_top, wall_bottom, wall_color, wall_side} !== e) begin
          n_errors++;
          $display("FAIL display_data: got top=%0d bot=%0d col=%0d side=%0d exp top=%0d bot=%0d col=%0d side=%0d",
                   wall_top, wall_bottom, wall_color, wall_side,
                   e[26:17], e[16:7], e[6:1], e[0]);
        end
      end
    end
  end

  initial begin
    logic [8:0] hgt;
    logic [15:0] wd;
    bit wr, fs, rd;
    logic [1:0] a;
    logic [15:0] d;
    int r;

    reset = 1'b1;
    frame_start = 1'b0;
    rd_en = 1'b0;
    rd_col = '0;
    bus.chipselect = 1'b0;
    bus.write = 1'b0;
    bus.read = 1'b0;
    bus.address = '0;
    bus.writedata = '0;
    m_front = 1'b0;
    m_pending = 1'b0;
    m_wrptr = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    n_checks++;
    if ({col_valid, wall_top, wall_bottom, wall_color, wall_side} !== 28'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got valid=%0d top=%0d bot=%0d col=%0d side=%0d required all 0",
               col_valid, wall_top, wall_bottom, wall_color, wall_side);
    end
    check_status("reset");
    check_reg(2'd0, 16'h0000, "addr0_reads_zero");

    // first swap
    do_swap();
    check_reg(2'd1, 16'h0001, "first_swap_status");
    check_status("first_swap");

    // stream 640 structured descriptors into bank 0
    for (int i = 0; i < 640; i++) begin
      hgt = 9'(i % 481);
      wd  = {6'(i), 1'(i), hgt};
      wr_word(2'd0, wd);
    end
    check_status("after_stream");
    do_swap();
    rd_req(10'd0);
    rd_req(10'd1);
    rd_req(10'd100);
    rd_req(10'd480);
    idle(3);

    // fill the other bank so every later read is defined
    for (int i = 0; i < 640; i++) wr_word(2'd0, 16'($urandom_range(0, 65535)));
    check_status("after_fill");

    // clamp, out-of-range column, rejected pointer write
    wr_word(2'd2, 16'd5);
    wr_word(2'd0, {6'h2A, 1'b1, 9'd511});
    wr_word(2'd2, 16'd800);
    check_reg(2'd2, 16'd6, "ptr_write_800_ignored");
    do_swap();
    rd_req(10'd5);
    rd_req(10'd700);
    rd_req(10'd1023);
    idle(3);

    // randomized mix of writes, swaps and display reads
    for (int it = 0; it < 500; it++) begin
      r  = $urandom_range(0, 9);
      wr = (r < 6);
      a  = (r < 4) ? 2'd0 : (r == 4) ? 2'd1 : 2'd2;
      case (a)
        2'd0:    d = 16'($urandom_range(0, 65535));
        2'd1:    d = 16'($urandom_range(0, 3));
        default: d = 16'($urandom_range(0, 1023));
      endcase
      fs = ($urandom_range(0, 5) == 0);
      rd = ($urandom_range(0, 1) == 1);
      step(wr, a, d, fs, rd, 10'($urandom_range(0, 720)));
      if (it % 25 == 0) check_status("random");
    end
    idle(3);

    // 641 writes wrap the pointer; column 0 holds the last word
    wr_word(2'd1, 16'h0002);
    check_reg(2'd2, 16'd0, "ptr_clear");
    for (int i = 0; i < 641; i++) wr_word(2'd0, 16'($urandom_range(0, 65535)));
    check_reg(2'd2, 16'd1, "ptr_wrap");
    do_swap();
    rd_req(10'd0);
    rd_req(10'd1);
    idle(3);

    // swap request in the same cycle as frame_start
    step(1'b1, 2'd1, 16'h0001, 1'b1, 1'b0, 10'd0);
    check_reg(2'd1, {14'b0, 1'b1, m_front}, "same_cycle_swap_req");
    step(1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 10'd0);
    check_reg(2'd1, {14'b0, 1'b0, m_front}, "deferred_swap_done");

    // swap landing between S1 and S2 must not alter the in-flight result
    wr_word(2'd1, 16'h0001);
    rd_req(10'd3);
    step(1'b0, 2'd0, 16'd0, 1'b1, 1'b1, 10'd4);
    idle(3);

    // reset while a request is in flight
    rd_en  = 1'b1;
    rd_col = 10'd7;
    exp_q.push_back(model_decode(10'd7));
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    n_checks++;
    if (col_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_kills_pipeline: col_valid=%0d required 0", col_valid);
    end
    reset = 1'b0;
    m_front = 1'b0;
    m_pending = 1'b0;
    m_wrptr = '0;
    idle(3);
    check_status("after_midreset");
    rd_req(10'd9);
    idle(3);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
